// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a byte stream over a valid/ready handshake. The stream is a 2-byte
// word count N (high byte first) followed by 4*N data bytes. Data bytes are
// assembled big-endian into 32-bit words, and each word is written to
// consecutive word addresses starting at BASE_ADDR. The processor is held in
// reset until the whole program has been written.

module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        IMWriteEn,
  output logic [31:0] IMWriteAddr,
  output logic [31:0] IMWriteData,
  output logic        CPUReset,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordsLoaded
);

  // The word index must reach 2^ADDR_WIDTH, so it needs one extra bit.
  localparam int unsigned IW = ADDR_WIDTH + 1;
  // Memory capacity in words, widened so that 2^16 is representable.
  localparam logic [16:0] CAP_WORDS = 17'(64'd1 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          post_rst_q;
  logic [15:0]   count_q, count_d;
  logic [IW-1:0] index_q, index_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [23:0]   sr_q, sr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [15:0]   words_q, words_d;

  logic          in_rst_s;
  logic          accept_s;
  logic [16:0]   hdr_n_s;
  logic [IW-1:0] idx_inc_s;

  // Outputs are held quiet while Reset is high and in the cycle right after.
  assign in_rst_s  = Reset | post_rst_q;
  assign accept_s  = ByteValid & ByteReady;
  // Full word count as it will be once the low header byte is taken.
  assign hdr_n_s   = {1'b0, count_q[15:8], ByteIn};
  assign idx_inc_s = index_q + IW'(1);

  // Remember whether the previous edge sampled Reset.
  always_ff @(posedge Clock) begin
    post_rst_q <= Reset;
  end

  // State register with synchronous reset into the header phase.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_HDR_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the load sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_HI: begin
        if (accept_s) begin
          state_d = S_HDR_LO;
        end else begin
          state_d = S_HDR_HI;
        end
      end
      S_HDR_LO: begin
        if (accept_s) begin
          if (hdr_n_s == 17'd0) begin
            state_d = S_DONE;
          end else if (hdr_n_s > CAP_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_HDR_LO;
        end
      end
      S_DATA: begin
        if (accept_s && (bidx_q == 2'd3)) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        if (17'(idx_inc_s) == {1'b0, count_q}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        if (Start) begin
          state_d = S_HDR_HI;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        // An illegal encoding parks the loader with the CPU held in reset.
        state_d = S_ERR;
      end
    endcase
  end

  // Output decode from the current state, forced quiet around reset.
  always_comb begin
    ByteReady = 1'b0;
    IMWriteEn = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    CPUReset  = 1'b1;
    if (in_rst_s) begin
      ByteReady = 1'b0;
    end else begin
      case (state_q)
        S_HDR_HI: ByteReady = 1'b1;
        S_HDR_LO: ByteReady = 1'b1;
        S_DATA:   ByteReady = 1'b1;
        S_WRITE:  IMWriteEn = 1'b1;
        S_DONE: begin
          CPUReset = 1'b0;
          Done     = 1'b1;
        end
        S_ERR:    Error = 1'b1;
        default:  Error = 1'b1;
      endcase
    end
  end

  // Datapath next values: header count, word assembly, write address/data.
  always_comb begin
    count_d = count_q;
    index_d = index_q;
    bidx_d  = bidx_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    case (state_q)
      S_HDR_HI: begin
        if (accept_s) begin
          count_d = {ByteIn, count_q[7:0]};
        end else begin
          count_d = count_q;
        end
      end
      S_HDR_LO: begin
        if (accept_s) begin
          count_d = {count_q[15:8], ByteIn};
          index_d = {IW{1'b0}};
          bidx_d  = 2'd0;
        end else begin
          count_d = count_q;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          sr_d   = {sr_q[15:0], ByteIn};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            // Latch the finished word and its address so they are stable
            // for the whole write cycle and hold afterwards.
            data_d = {sr_q, ByteIn};
            addr_d = BASE_ADDR + (32'(index_q) << 2'd2);
          end else begin
            data_d = data_q;
          end
        end else begin
          sr_d = sr_q;
        end
      end
      S_WRITE: begin
        index_d = idx_inc_s;
        words_d = words_q + 16'd1;
      end
      S_DONE: begin
        if (Start) begin
          index_d = {IW{1'b0}};
          words_d = 16'd0;
        end else begin
          words_d = words_q;
        end
      end
      S_ERR: begin
        words_d = words_q;
      end
      default: begin
        words_d = words_q;
      end
    endcase
  end

  // Datapath registers; reset aborts a load but leaves memory untouched.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= 16'd0;
      index_q <= {IW{1'b0}};
      bidx_q  <= 2'd0;
      sr_q    <= 24'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      words_q <= 16'd0;
    end else begin
      count_q <= count_d;
      index_q <= index_d;
      bidx_q  <= bidx_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
    end
  end

  assign IMWriteAddr = addr_q;
  assign IMWriteData = data_q;
  assign WordsLoaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scoreboard of expected memory writes checked
// against every IMWriteEn pulse, plus status checks at key points.

module tb_imem_loader;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        IMWriteEn;
  logic [31:0] IMWriteAddr;
  logic [31:0] IMWriteData;
  logic        CPUReset;
  logic        Done;
  logic        Error;
  logic [15:0] WordsLoaded;

  int n_vectors     = 0;
  int n_miscompares = 0;
  int n_writes      = 0;
  logic [63:0] exp_q[$];

  imem_loader #(
    .ADDR_WIDTH(8),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .Clock      (clk),
    .Reset      (Reset),
    .Start      (Start),
    .ByteIn     (ByteIn),
    .ByteValid  (ByteValid),
    .ByteReady  (ByteReady),
    .IMWriteEn  (IMWriteEn),
    .IMWriteAddr(IMWriteAddr),
    .IMWriteData(IMWriteData),
    .CPUReset   (CPUReset),
    .Done       (Done),
    .Error      (Error),
    .WordsLoaded(WordsLoaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Each write pulse is matched against the oldest expected write.
  always @(negedge clk) begin
    logic [63:0] e;
    if (IMWriteEn === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("wr_addr", IMWriteAddr, e[63:32]);
        check_val("wr_data", IMWriteData, e[31:0]);
      end
    end
  end

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Called on a falling edge; returns on the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    ByteIn    = b;
    ByteValid = 1'b1;
    while (ByteReady !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check_val("byte_timeout", 32'd0, 32'd1);
    @(negedge clk);
    ByteValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (Done !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_val("done_seen", Done, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset     = 1'b1;
    Start     = 1'b0;
    ByteValid = 1'b0;
    #1;
    check_val("rst_cpureset", CPUReset, 32'd1);
    check_val("rst_ready", ByteReady, 32'd0);
    check_val("rst_error", Error, 32'd0);
    check_val("rst_wen", IMWriteEn, 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    #1;
    check_val("post_rst_ready", ByteReady, 32'd0);
    check_val("post_rst_cpureset", CPUReset, 32'd1);
    check_val("post_rst_words", WordsLoaded, 32'd0);
    check_val("post_rst_addr", IMWriteAddr, 32'd0);
    check_val("post_rst_data", IMWriteData, 32'd0);
    check_val("post_rst_done", Done, 32'd0);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check_val("start_cpureset", CPUReset, 32'd1);
    check_val("start_done", Done, 32'd0);
    check_val("start_words", WordsLoaded, 32'd0);
  endtask

  initial begin
    int w0;
    logic [31:0] wd;
    Reset     = 1'b0;
    Start     = 1'b0;
    ByteIn    = 8'h00;
    ByteValid = 1'b0;

    // Basic two-word load.
    do_reset();
    push_write(32'h0, 32'hDEADBEEF);
    push_write(32'h4, 32'h12345678);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'hDEADBEEF);
    send_word(32'h12345678);
    wait_done(50);
    check_val("t1_cpureset", CPUReset, 32'd0);
    check_val("t1_words", WordsLoaded, 32'd2);
    check_val("t1_nwrites", n_writes, 32'd2);
    check_val("t1_ready", ByteReady, 32'd0);
    check_val("t1_sb_empty", exp_q.size(), 32'd0);
    check_val("t1_addr_hold", IMWriteAddr, 32'h4);

    // Start and a valid byte on the same edge: Start wins, byte is kept.
    Start     = 1'b1;
    ByteIn    = 8'h00;
    ByteValid = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check_val("t2_cpureset", CPUReset, 32'd1);
    check_val("t2_words", WordsLoaded, 32'd0);
    check_val("t2_ready", ByteReady, 32'd1);
    push_write(32'h0, 32'hCAFEBABE);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hCAFEBABE);
    wait_done(50);
    check_val("t2_words_end", WordsLoaded, 32'd1);
    check_val("t2_cpureset_end", CPUReset, 32'd0);

    // Empty program.
    w0 = n_writes;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    check_val("t3_done", Done, 32'd1);
    check_val("t3_words", WordsLoaded, 32'd0);
    check_val("t3_nowrite", n_writes - w0, 32'd0);

    // Valid toggling 1,0,0,1,... with junk on idle cycles.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    push_write(32'h0, 32'hAABBCCDD);
    wd = 32'hAABBCCDD;
    for (int i = 3; i >= 0; i--) begin
      send_byte(wd[8*i +: 8]);
      ByteIn = 8'h55;
      repeat (2) @(negedge clk);
    end
    wait_done(50);
    check_val("t4_words", WordsLoaded, 32'd1);

    // Reset in the middle of the first word, then a fresh load.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hDE);
    send_byte(8'hAD);
    do_reset();
    push_write(32'h0, 32'h11223344);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h11223344);
    wait_done(50);
    check_val("t5_words", WordsLoaded, 32'd1);

    // Word count one past capacity.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    check_val("t6_error", Error, 32'd1);
    check_val("t6_cpureset", CPUReset, 32'd1);
    check_val("t6_ready", ByteReady, 32'd0);
    Start     = 1'b1;
    ByteValid = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    ByteValid = 1'b0;
    check_val("t6_error_hold", Error, 32'd1);
    check_val("t6_done", Done, 32'd0);
    check_val("t6_ready_hold", ByteReady, 32'd0);

    // Exactly full memory.
    do_reset();
    check_val("t7_error_clr", Error, 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      wd = {8'(i), 8'(i) ^ 8'hA5, 8'h3C, ~8'(i)};
      push_write(32'(i) * 32'd4, wd);
      send_word(wd);
    end
    wait_done(50);
    check_val("t7_words", WordsLoaded, 32'd256);
    check_val("t7_last_addr", IMWriteAddr, 32'h3FC);
    check_val("t7_error", Error, 32'd0);
    check_val("t7_sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory that the single-cycle datapath fetches from. It accepts a byte stream over a valid/ready handshake. It assembles big-endian 32-bit words and writes them to consecutive word-aligned instruction memory addresses. It holds the processor in reset until the whole program is written.

Parameters:
ADDR_WIDTH, 8, word-address bits of instruction memory (capacity 2^ADDR_WIDTH words)
BASE_ADDR, 32'h0000_0000, byte address of first word written (word-aligned)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  in DONE, 1-cycle pulse restarts a load
ByteIn  input  8  stream byte
ByteValid  input  1  ByteIn is valid
ByteReady  output  1  loader accepts ByteIn this cycle
IMWriteEn  output  1  instruction memory write strobe
IMWriteAddr  output  32  byte address of write (BASE_ADDR + 4*index)
IMWriteData  output  32  word to write
CPUReset  output  1  reset request to the processor datapath
Done  output  1  load complete
Error  output  1  header word count exceeded capacity
WordsLoaded  output  16  number of words written in the current load

Behaviour:
- Handshake: a byte transfers on a rising edge where ByteValid=1 and ByteReady=1. ByteIn is ignored otherwise. ByteValid may drop at any time.
- Stream format: 2-byte header (word count N, high byte first), then 4*N data bytes. Each word is big-endian: the first byte goes to [31:24].
- Reset: while Reset=1 at an edge, state goes to HDR_HI, index and count clear, IMWriteAddr=0, IMWriteData=0, WordsLoaded=0.
- Output decode: while Reset is high and in the first cycle after it, CPUReset=1 and ByteReady=0. Also IMWriteEn=0, Done=0, Error=0.
- Reset mid-load aborts the load. Words already written stay in memory, and WordsLoaded clears.
- States and outputs:
  - HDR_HI: ByteReady=1. Accept a byte: count[15:8] <= byte, go to HDR_LO.
  - HDR_LO: ByteReady=1. Accept a byte: count[7:0] <= byte. Then branch on the full count: N=0 -> DONE; N > 2^ADDR_WIDTH -> ERR; else -> DATA with byte index 0.
  - DATA: ByteReady=1. Accept a byte: shift register <= {sr[23:0], byte}, byte index++. On the 4th byte go to WRITE.
  - WRITE: ByteReady=0, IMWriteEn=1 for exactly one cycle. IMWriteData=assembled word, IMWriteAddr=BASE_ADDR+4*index. Next edge: index++, WordsLoaded++. Then index==N -> DONE, else DATA.
  - DONE: CPUReset=0, Done=1, ByteReady=0. Start=1 clears index/WordsLoaded and goes to HDR_HI with CPUReset=1.
  - ERR: CPUReset=1, Error=1, ByteReady=0. Stays in ERR until Reset; Start is ignored.
- CPUReset=1 in every state except DONE. The transition DONE->HDR_HI reasserts it on the next cycle.
- Latency: the 4th byte of a word is accepted at edge k, and IMWriteEn is high during cycle k+1. Minimum 5 cycles per word.
- Address arithmetic: index is ADDR_WIDTH+1 bits. IMWriteAddr is a 32-bit sum that never wraps within a valid load, because N <= 2^ADDR_WIDTH. N = 2^ADDR_WIDTH exactly is legal and fills memory.
- IMWriteAddr and IMWriteData hold their last values outside WRITE.
- Start outside DONE is ignored.
- ByteValid and Start arriving on the same edge in DONE: Start wins. The byte is not consumed, because ByteReady=0.

Test Plan:
- Reset, then stream 00 02 DE AD BE EF 12 34 56 78 with ByteValid always 1 -> IMWriteEn pulses twice: addr 0x0 data 0xDEADBEEF, then addr 0x4 data 0x12345678. Then Done=1, CPUReset=0, WordsLoaded=2.
- Header 00 00 -> DONE the edge after the second byte. No IMWriteEn pulse, WordsLoaded=0.
- ADDR_WIDTH=8, header 01 01 (257) -> Error=1, CPUReset=1, ByteReady=0 stays until Reset. Header 01 00 with 1024 bytes -> 256 writes, last addr 0x3FC.
- One word AA BB CC DD with ByteValid toggling 1,0,0,1,... -> only valid bytes are taken, and the write data is still 0xAABBCCDD.
- Reset asserted after 2 data bytes of word 1 -> state HDR_HI, WordsLoaded=0. A following stream 00 01 11 22 33 44 writes 0x11223344 at addr 0x0.
- After Done, pulse Start and send 00 01 CA FE BA BE -> CPUReset rises the next cycle and one write lands at addr 0x0 with data 0xCAFEBABE. Done then returns.
